// File: rtl/tile_load_sequencer.sv
// Tile load sequencer: steers the host data window into the ifmap/weight/bias
// SRAMs by word counting, kicks the compute controller per pass, raises the
// host interrupt on pass completion and serves ofmap readback after the final pass.
module tile_load_sequencer #(
  parameter int IFMAP_WORDS  = 16,
  parameter int WEIGHT_WORDS = 1024,
  parameter int BIAS_WORDS   = 64,
  parameter int OFMAP_WORDS  = 64,
  parameter int NUM_PASSES   = 2,
  parameter int ADDR_W       = 11
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [31:0]       wr_data,
  output logic              wr_ready,
  input  logic              rd_en,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  output logic [31:0]       cfg_out,
  output logic              ifmap_we,
  output logic              weight_we,
  output logic              bias_we,
  output logic [ADDR_W-1:0] sram_waddr,
  output logic [31:0]       sram_wdata,
  output logic              ofmap_re,
  output logic [ADDR_W-1:0] ofmap_raddr,
  input  logic [31:0]       ofmap_rdata,
  output logic              comp_start,
  input  logic              comp_done,
  output logic              ASIC_interrupt,
  output logic              busy
);

  localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [ADDR_W-1:0] IF_LAST = ADDR_W'(IFMAP_WORDS - 1);
  localparam logic [ADDR_W-1:0] W_LAST  = ADDR_W'(WEIGHT_WORDS - 1);
  localparam logic [ADDR_W-1:0] B_LAST  = ADDR_W'(BIAS_WORDS - 1);
  localparam logic [ADDR_W-1:0] OF_LAST = ADDR_W'(OFMAP_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_IF, S_LD_W, S_LD_B, S_START, S_COMPUTE, S_WAIT_HOST, S_READOUT
  } state_t;

  state_t              state, state_nxt, load_seg;
  logic [ADDR_W-1:0]   word_cnt, word_nxt;
  logic [ADDR_W-1:0]   rd_cnt, rd_cnt_nxt;
  logic [PASS_W-1:0]   pass_cnt, pass_nxt;
  logic [31:0]         cfg_q, cfg_nxt;
  logic                irq_q, irq_nxt;
  logic                rd_valid_q, rd_src_q, rd_src_nxt;
  logic                wr_cfg, wr_dat, load_ok, host_ok;

  assign wr_cfg  = wr_en && (wr_addr == 4'h0);
  assign wr_dat  = wr_en && (wr_addr == 4'h4);
  assign load_ok = (state == S_LD_IF) || (state == S_LD_W) ||
                   (state == S_LD_B)  || (state == S_WAIT_HOST);
  assign host_ok = (state == S_IDLE) || (state == S_READOUT);

  // State and counter registers; everything returns to its idle value on reset.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= S_IDLE;
      word_cnt   <= '0;
      rd_cnt     <= '0;
      pass_cnt   <= '0;
      cfg_q      <= '0;
      irq_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_src_q   <= 1'b0;
    end else begin
      state      <= state_nxt;
      word_cnt   <= word_nxt;
      rd_cnt     <= rd_cnt_nxt;
      pass_cnt   <= pass_nxt;
      cfg_q      <= cfg_nxt;
      irq_q      <= irq_nxt;
      rd_valid_q <= rd_ready;
      rd_src_q   <= rd_src_nxt;
    end
  end

  // Next-state, counter updates and same-cycle SRAM/handshake strobes.
  always_comb begin
    state_nxt   = state;
    word_nxt    = word_cnt;
    rd_cnt_nxt  = rd_cnt;
    pass_nxt    = pass_cnt;
    cfg_nxt     = cfg_q;
    irq_nxt     = irq_q;
    rd_src_nxt  = 1'b0;
    wr_ready    = 1'b0;
    ifmap_we    = 1'b0;
    weight_we   = 1'b0;
    bias_we     = 1'b0;
    sram_waddr  = '0;
    sram_wdata  = '0;
    rd_ready    = 1'b0;
    ofmap_re    = 1'b0;
    ofmap_raddr = '0;
    // A host write in WAIT_HOST is the first ifmap word of the next pass.
    load_seg    = (state == S_WAIT_HOST) ? S_LD_IF : state;

    case (state)
      S_START:   state_nxt = S_COMPUTE;
      S_COMPUTE: begin
        if (comp_done) begin
          irq_nxt = 1'b1;
          if (int'(pass_cnt) + 1 < NUM_PASSES) begin
            pass_nxt  = pass_cnt + PASS_W'(1);
            state_nxt = S_WAIT_HOST;
          end else begin
            rd_cnt_nxt = '0;
            state_nxt  = S_READOUT;
          end
        end
      end
      default: ;
    endcase

    // Reads: ofmap fetch in READOUT (one outstanding), zero data elsewhere.
    if (rd_en) begin
      if (state == S_READOUT) begin
        if (!rd_valid_q) begin
          rd_ready    = 1'b1;
          ofmap_re    = 1'b1;
          ofmap_raddr = rd_cnt;
          rd_src_nxt  = 1'b1;
          irq_nxt     = 1'b0;
          rd_cnt_nxt  = rd_cnt + ADDR_W'(1);
          if (rd_cnt == OF_LAST) state_nxt = S_IDLE;
        end
      end else begin
        rd_ready = 1'b1;
      end
    end

    // Writes: data window steering, config latch, everything else dropped.
    if (wr_dat) begin
      if (load_ok) begin
        wr_ready   = 1'b1;
        sram_waddr = word_cnt;
        sram_wdata = wr_data;
        word_nxt   = word_cnt + ADDR_W'(1);
        state_nxt  = load_seg;
        if (state == S_WAIT_HOST) irq_nxt = 1'b0;
        case (load_seg)
          S_LD_IF: begin
            ifmap_we = 1'b1;
            if (word_cnt == IF_LAST) begin
              word_nxt  = '0;
              state_nxt = S_LD_W;
            end
          end
          S_LD_W: begin
            weight_we = 1'b1;
            if (word_cnt == W_LAST) begin
              word_nxt  = '0;
              state_nxt = (pass_cnt == '0) ? S_LD_B : S_START;
            end
          end
          S_LD_B: begin
            bias_we = 1'b1;
            if (word_cnt == B_LAST) begin
              word_nxt  = '0;
              state_nxt = S_START;
            end
          end
          default: ;
        endcase
      end else if (host_ok) begin
        wr_ready = 1'b1;
      end
    end else if (wr_cfg) begin
      if (host_ok) begin
        wr_ready = 1'b1;
        cfg_nxt  = wr_data;
        irq_nxt  = 1'b0;
        if (wr_data[3]) begin
          pass_nxt  = '0;
          word_nxt  = '0;
          state_nxt = S_LD_IF;
        end
      end
    end else if (wr_en) begin
      wr_ready = 1'b1;
    end
  end

  assign rd_valid       = rd_valid_q;
  assign rd_data        = (rd_valid_q && rd_src_q) ? ofmap_rdata : '0;
  assign cfg_out        = cfg_q;
  assign ASIC_interrupt = irq_q;
  assign comp_start     = (state == S_START);
  assign busy           = (state != S_IDLE);

endmodule

// File: tb/tb_tile_load_sequencer.sv
// Randomized bench for tile_load_sequencer: expected SRAM routing is derived
// from the word index of each pass; ofmap SRAM is a simple address+base model.
module tb_tile_load_sequencer;

  localparam int IFW = 16;
  localparam int WW  = 1024;
  localparam int BW  = 64;
  localparam int OFW = 64;
  localparam int AW  = 11;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic          wr_en, rd_en, comp_done;
  logic [3:0]    wr_addr;
  logic [31:0]   wr_data;
  logic          wr_ready, rd_ready, rd_valid;
  logic [31:0]   rd_data, cfg_out, sram_wdata;
  logic          ifmap_we, weight_we, bias_we, ofmap_re, comp_start, ASIC_interrupt, busy;
  logic [AW-1:0] sram_waddr, ofmap_raddr;
  logic [31:0]   ofmap_rdata = '0;
  logic [2:0]    we3;

  int          n_chk = 0;
  int          n_err = 0;
  int          n_start = 0;
  logic [31:0] exp_cfg = '0;
  logic [31:0] ofm_base = '0;

  tile_load_sequencer dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .cfg_out(cfg_out),
    .ifmap_we(ifmap_we), .weight_we(weight_we), .bias_we(bias_we),
    .sram_waddr(sram_waddr), .sram_wdata(sram_wdata),
    .ofmap_re(ofmap_re), .ofmap_raddr(ofmap_raddr), .ofmap_rdata(ofmap_rdata),
    .comp_start(comp_start), .comp_done(comp_done),
    .ASIC_interrupt(ASIC_interrupt), .busy(busy)
  );

  assign we3 = {ifmap_we, weight_we, bias_we};

  initial forever #5 ACLK = ~ACLK;

  // Ofmap SRAM: one-cycle read latency, content = base + address.
  always @(posedge ACLK) if (ofmap_re) ofmap_rdata <= ofm_base + 32'(ofmap_raddr);

  // Count start pulses seen by the controller.
  always @(posedge ACLK) if (comp_start) n_start <= n_start + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] a, input logic [31:0] d,
                       input logic re, input logic cd);
    @(negedge ACLK);
    wr_en = we; wr_addr = a; wr_data = d; rd_en = re; comp_done = cd;
    #2;
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_ctl"}, {22'd0, wr_ready, ifmap_we, weight_we, bias_we, rd_ready, rd_valid,
                        ofmap_re, comp_start, ASIC_interrupt, busy}, 32'd0);
    chk({tag, "_cfg"}, cfg_out, 32'd0);
    chk({tag, "_rdata"}, rd_data, 32'd0);
    chk({tag, "_waddr"}, 32'(sram_waddr), 32'd0);
    chk({tag, "_wdata"}, sram_wdata, 32'd0);
    chk({tag, "_raddr"}, 32'(ofmap_raddr), 32'd0);
  endtask

  // Reference routing of the i-th accepted data word of a pass.
  function automatic void exp_load(input int i, output logic [2:0] we, output logic [AW-1:0] a);
    if (i < IFW) begin
      we = 3'b100; a = AW'(i);
    end else if (i < IFW + WW) begin
      we = 3'b010; a = AW'(i - IFW);
    end else begin
      we = 3'b001; a = AW'(i - IFW - WW);
    end
  endfunction

  task automatic load_pass(input int n_words, input int cfg_at, input logic exp_irq);
    int            i;
    logic          prev_re, cfg_done, re;
    logic [2:0]    ew;
    logic [AW-1:0] ea;
    logic [31:0]   d;
    i = 0; prev_re = 1'b0; cfg_done = 1'b0;
    while (i < n_words) begin
      re = (i != n_words - 1) && ($urandom_range(0, 3) == 0);
      d  = $urandom;
      if (!cfg_done && i == cfg_at) begin
        cfg_done = 1'b1;
        re = 1'b0;
        drive(1'b1, 4'h0, d | 32'h8, 1'b0, 1'b0);
        chk("cfg_stall", {28'd0, wr_ready, we3}, 32'd0);
      end else if ($urandom_range(0, 4) == 0) begin
        drive(1'b0, 4'h4, d, re, 1'b0);
        chk("gap_we", {28'd0, wr_ready, we3}, 32'd0);
      end else begin
        exp_load(i, ew, ea);
        drive(1'b1, 4'h4, d, re, 1'b0);
        chk("wr_ack", {28'd0, wr_ready, we3}, {28'd0, 1'b1, ew});
        chk("waddr", 32'(sram_waddr), 32'(ea));
        chk("wdata", sram_wdata, d);
        chk("irq_load", 32'(ASIC_interrupt), (i == 0) ? 32'(exp_irq) : 32'd0);
        i++;
      end
      if (re) chk("rd_side", {30'd0, rd_ready, ofmap_re}, 32'd2);
      chk("rd_valid_side", 32'(rd_valid), 32'(prev_re));
      if (prev_re) chk("rd_zero", rd_data, 32'd0);
      chk("cfg_hold", cfg_out, exp_cfg);
      prev_re = re;
    end
  endtask

  task automatic compute_phase();
    int n;
    drive(1'b1, 4'h4, $urandom, 1'b0, 1'b0);
    chk("start_pulse", {26'd0, comp_start, wr_ready, we3, busy}, 32'h21);
    n = $urandom_range(1, 4);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, 4'h4, $urandom, 1'b0, 1'b0);
      chk("comp_stall", {26'd0, comp_start, wr_ready, we3, busy}, 32'h01);
    end
    drive(1'b0, 4'h0, 32'd0, 1'b0, 1'b1);
    chk("irq_pre", 32'(ASIC_interrupt), 32'd0);
    drive(1'b0, 4'h0, 32'd0, 1'b0, 1'b0);
    chk("irq_set", {30'd0, ASIC_interrupt, busy}, 32'd3);
  endtask

  task automatic readout();
    int   k;
    logic re;
    for (int c = 0; c < 2 * OFW; c++) begin
      k = c / 2;
      if (c % 2 == 0) begin
        drive(1'b0, 4'h0, 32'd0, 1'b1, 1'b0);
        chk("rd_acc", {29'd0, rd_ready, ofmap_re, rd_valid}, 32'd6);
        chk("rd_addr", 32'(ofmap_raddr), 32'(k));
        chk("rd_irq", 32'(ASIC_interrupt), (k == 0) ? 32'd1 : 32'd0);
      end else begin
        re = (k != OFW - 1) && ($urandom_range(0, 1) == 1);
        drive(1'b0, 4'h0, 32'd0, re, 1'b0);
        chk("rd_ret", {29'd0, rd_ready, ofmap_re, rd_valid}, 32'd1);
        chk("rd_data", rd_data, ofm_base + 32'(k));
        if (k == OFW - 1) chk("rd_idle", 32'(busy), 32'd0);
      end
    end
  endtask

  initial begin
    ofm_base = $urandom;
    ARESETn = 1'b0;
    wr_en = 1'b0; wr_addr = 4'h0; wr_data = 32'd0; rd_en = 1'b0; comp_done = 1'b0;
    repeat (3) @(posedge ACLK);
    #1 zero_chk("rst");
    @(negedge ACLK) ARESETn = 1'b1;
    #2 zero_chk("rst_rel");

    // Pass 0: ifmap + weights + bias, with a stalled config write mid-weights.
    drive(1'b1, 4'h0, 32'h0000_0378, 1'b0, 1'b0);
    chk("cfg_ack", 32'(wr_ready), 32'd1);
    exp_cfg = 32'h0000_0378;
    load_pass(IFW + WW + BW, 600, 1'b0);
    compute_phase();
    chk("n_start_p0", 32'(n_start), 32'd1);

    // Pass 1: no bias segment, interrupt cleared by the first data word.
    load_pass(IFW + WW, -1, 1'b1);
    compute_phase();
    chk("n_start_p1", 32'(n_start), 32'd2);

    readout();
    drive(1'b0, 4'h0, 32'd0, 1'b0, 1'b0);
    chk("post_rd", {30'd0, rd_valid, busy}, 32'd0);

    // IDLE behaviour: stray done ignored, plain config, dropped data, zero read.
    drive(1'b0, 4'h0, 32'd0, 1'b0, 1'b1);
    drive(1'b0, 4'h0, 32'd0, 1'b0, 1'b0);
    chk("idle_done", {30'd0, ASIC_interrupt, busy}, 32'd0);
    drive(1'b1, 4'h0, 32'h0000_0012, 1'b0, 1'b0);
    chk("cfg_idle_ack", 32'(wr_ready), 32'd1);
    exp_cfg = 32'h0000_0012;
    drive(1'b1, 4'h4, $urandom, 1'b1, 1'b0);
    chk("idle_drop", {26'd0, wr_ready, we3, rd_ready, ofmap_re}, 32'h22);
    chk("cfg_idle", cfg_out, exp_cfg);
    chk("idle_busy", 32'(busy), 32'd0);
    drive(1'b0, 4'h0, 32'd0, 1'b0, 1'b0);
    chk("idle_rd", {31'd0, rd_valid}, 32'd1);
    chk("idle_rdata", rd_data, 32'd0);

    // Mid-load asynchronous reset, then restart from ifmap word 0.
    drive(1'b1, 4'h0, 32'h0000_0008, 1'b0, 1'b0);
    exp_cfg = 32'h0000_0008;
    load_pass(500, -1, 1'b0);
    @(negedge ACLK);
    wr_en = 1'b0; rd_en = 1'b0; comp_done = 1'b0; wr_data = 32'd0; wr_addr = 4'h0;
    #3 ARESETn = 1'b0;
    #1 chk("async_rst", {cfg_out[30:0], busy}, 32'd0);
    repeat (3) @(posedge ACLK);
    @(negedge ACLK) ARESETn = 1'b1;
    #2 zero_chk("mid_rst");
    drive(1'b1, 4'h0, 32'h0000_0008, 1'b0, 1'b0);
    chk("cfg_re_ack", 32'(wr_ready), 32'd1);
    load_pass(IFW + 4, -1, 1'b0);
    chk("n_start_total", 32'(n_start), 32'd2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
